// File: rtl/exec_ctrl_pkg.sv
// Encodings shared by the execute-stage operand controller: ALU input-1
// sources, forwarding selects and the multi-cycle sequencing states.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    OP1_REG  = 2'b00,
    OP1_PC   = 2'b01,
    OP1_ZERO = 2'b10,
    OP1_RSVD = 2'b11
  } op1_src_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MD_BUSY = 2'b01,
    ST_MD_DONE = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/fwd_compare.sv
// Forwarding source select for one execute operand: the younger MEM result
// wins over WB, and x0 is never forwarded.
module fwd_compare
  import exec_ctrl_pkg::*;
(
  input  logic [4:0] exeRs_i,
  input  logic       exeUse_i,
  input  logic [4:0] memRd_i,
  input  logic       memRegWrite_i,
  input  logic [4:0] wbRd_i,
  input  logic       wbRegWrite_i,
  output logic [1:0] fwdSelect_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = exeUse_i && memRegWrite_i && (memRd_i != 5'd0) && (memRd_i == exeRs_i);
  assign wb_hit  = exeUse_i && wbRegWrite_i  && (wbRd_i  != 5'd0) && (wbRd_i  == exeRs_i);

  always_comb begin
    fwdSelect_o = FWD_RF;
    if (mem_hit) begin
      fwdSelect_o = FWD_MEM;
    end else if (wb_hit) begin
      fwdSelect_o = FWD_WB;
    end
  end

endmodule

// File: rtl/execute_operand_controller.sv
// Execute-stage operand controller: ALU input-1 select, operand forwarding,
// load-use stall/bubble and multi-cycle (mul/div) stall sequencing.
module execute_operand_controller
  import exec_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] decRs1,
  input  logic [4:0] decRs2,
  input  logic       decUse1,
  input  logic       decUse2,
  input  logic [4:0] exeRs1,
  input  logic [4:0] exeRs2,
  input  logic       exeUse1,
  input  logic       exeUse2,
  input  logic [1:0] exeOp1Src,
  input  logic [4:0] exeRd,
  input  logic       exeMemRead,
  input  logic       exeMdStart,
  input  logic [4:0] memRd,
  input  logic       memRegWrite,
  input  logic [4:0] wbRd,
  input  logic       wbRegWrite,
  output logic [1:0] input1Select,
  output logic [1:0] fwd1Select,
  output logic [1:0] fwd2Select,
  output logic       stall,
  output logic       bubble,
  output logic       mdBusy,
  output logic       mdResultValid
);

  if (MD_LATENCY < 2 || MD_LATENCY > 32) begin : g_bad_latency
    $error("execute_operand_controller: MD_LATENCY must be in 2..32");
  end

  localparam int CNT_W = $clog2(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 2);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             stall_c, bubble_c, busy_c, valid_c;

  assign input1Select = (exeOp1Src == OP1_RSVD) ? OP1_REG : exeOp1Src;

  fwd_compare u_fwd1 (
    .exeRs_i       (exeRs1),
    .exeUse_i      (exeUse1),
    .memRd_i       (memRd),
    .memRegWrite_i (memRegWrite),
    .wbRd_i        (wbRd),
    .wbRegWrite_i  (wbRegWrite),
    .fwdSelect_o   (fwd1Select)
  );

  fwd_compare u_fwd2 (
    .exeRs_i       (exeRs2),
    .exeUse_i      (exeUse2),
    .memRd_i       (memRd),
    .memRegWrite_i (memRegWrite),
    .wbRd_i        (wbRd),
    .wbRegWrite_i  (wbRegWrite),
    .fwdSelect_o   (fwd2Select)
  );

  assign load_use = exeMemRead && (exeRd != 5'd0) &&
                    ((decUse1 && (decRs1 == exeRd)) || (decUse2 && (decRs2 == exeRd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The start cycle counts as the first stall cycle, so MD_BUSY lasts
  // MD_LATENCY-2 cycles; with MD_LATENCY==2 there is no busy phase at all.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    busy_c   = 1'b0;
    valid_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (exeMdStart) begin
          stall_c = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = (MD_LATENCY == 2) ? ST_MD_DONE : ST_MD_BUSY;
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      ST_MD_BUSY: begin
        stall_c = 1'b1;
        busy_c  = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_MD_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MD_DONE: begin
        valid_c = 1'b1;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
    endcase
  end

  // Load-use is decoded combinationally, so reset must gate it directly.
  assign stall         = rst_n & stall_c;
  assign bubble        = rst_n & bubble_c;
  assign mdBusy        = rst_n & busy_c;
  assign mdResultValid = rst_n & valid_c;

endmodule
